// File: rtl/div_seq.sv
// Iterative restoring divider for the execute stage: DIV/DIVU in 32 shift-subtract
// steps, returning {remainder, quotient}, with annul and divide-by-zero handling.
module div_seq #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned RES_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   dvs_q;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quo_q;
  logic                neg_quo_q;
  logic                neg_rem_q;
  logic [RES_W-1:0]    result_q;
  logic                ready_q;

  logic [DATA_W-1:0]   op1_abs;
  logic [DATA_W-1:0]   op2_abs;
  logic [DATA_W:0]     shifted;
  logic [DATA_W:0]     diff;
  logic [DATA_W-1:0]   rem_d;
  logic [DATA_W-1:0]   quo_d;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  // Operand magnitudes, one restoring step, and the final sign fix-up.
  // quo_q starts as the dividend; its MSB feeds the remainder while quotient bits enter at the LSB.
  always_comb begin
    op1_abs = opdata1_i;
    op2_abs = opdata2_i;
    if (signed_div_i && opdata1_i[DATA_W-1]) op1_abs = -opdata1_i;
    if (signed_div_i && opdata2_i[DATA_W-1]) op2_abs = -opdata2_i;

    shifted = {rem_q, quo_q[DATA_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    rem_d   = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_d   = {quo_q[DATA_W-2:0], ~diff[DATA_W]};

    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_FREE;
      cnt_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (start_i && !annul_i) begin
            dvs_q     <= op2_abs;
            quo_q     <= op1_abs;
            rem_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_q <= signed_div_i && opdata1_i[DATA_W-1];
            state_q   <= (opdata2_i == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: begin
          result_q <= '0;
          if (annul_i) begin
            ready_q <= 1'b0;
            state_q <= S_FREE;
          end else begin
            ready_q <= 1'b1;
            state_q <= S_END;
          end
        end
        S_ON: begin
          if (annul_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            state_q  <= S_FREE;
          end else if (cnt_q != CNT_W'(DATA_W)) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            result_q <= {rem_fix, quo_fix};
            ready_q  <= 1'b1;
            state_q  <= S_END;
          end
        end
        S_END: begin
          if (!start_i) begin
            ready_q  <= 1'b0;
            result_q <= '0;
            state_q  <= S_FREE;
          end
        end
        default: state_q <= S_FREE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed vectors, annul/reset mid-operation, and
// randomized DIV/DIVU checked against an arithmetic reference model.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_tests = 0;
  int n_fail  = 0;

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: C-style truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  // Raise start with operands, count edges until ready_o; operands are scrambled mid-run.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    lat          = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (ready_o === 1'b1) begin
        lat = i;
        break;
      end
      if (i == 3) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
    end
    res = result_o;
  endtask

  task automatic drop_start();
    start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    n_tests++;
    if (result_o !== 64'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", result_o); end
    rst = 1'b1;
  endtask

  task automatic test_unsigned_basic();
    logic [63:0] res; int lat;
    run_op(1'b0, 32'd100, 32'd7, res, lat);
    n_tests++;
    if (lat != 34) begin n_fail++; $display("FAIL basic_latency got=%0d exp=34", lat); end
    n_tests++;
    if (res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL basic_result got=%h exp=%h", res, {32'd2, 32'd14}); end
    drop_start();
    n_tests++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++; $display("FAIL basic_drop got ready=%b result=%h exp ready=0 result=0", ready_o, result_o);
    end
  endtask

  task automatic test_signed_vectors();
    bit          sg [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] va [4] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] vb [4] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF};
    logic [63:0] ve [4] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h1, 32'hFFFF_FFFD},
                            {32'h1, 32'h7FFF_FFFC}, {32'h0, 32'h8000_0000}};
    logic [63:0] res; int lat;
    for (int k = 0; k < 4; k++) begin
      run_op(sg[k], va[k], vb[k], res, lat);
      n_tests++;
      if (res !== ve[k] || lat != 34) begin
        n_fail++; $display("FAIL vector_%0d got=%h lat=%0d exp=%h lat=34", k, res, lat, ve[k]);
      end
      drop_start();
    end
  endtask

  task automatic test_div_zero();
    logic [63:0] res; int lat; int bad;
    run_op(1'b0, 32'd5, 32'd0, res, lat);
    n_tests++;
    if (lat != 2 || res !== 64'd0) begin
      n_fail++; $display("FAIL divzero got lat=%0d result=%h exp lat=2 result=0", lat, res);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b1 || result_o !== 64'd0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL divzero_hold got=%0d unstable edges exp=0", bad); end
    drop_start();
    n_tests++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL divzero_drop got ready=%b exp=0", ready_o); end
  endtask

  task automatic test_annul();
    logic [63:0] res; int lat; int bad;
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    bad = 0;
    for (int e = 11; e <= 40; e++) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL annul_quiet got=%0d ready edges exp=0", bad); end
    run_op(1'b0, 32'd9, 32'd3, res, lat);
    n_tests++;
    if (lat != 34 || res !== {32'd0, 32'd3}) begin
      n_fail++; $display("FAIL annul_restart got lat=%0d result=%h exp lat=34 result=%h", lat, res, {32'd0, 32'd3});
    end
    drop_start();
  endtask

  task automatic test_reset_mid();
    logic [63:0] res; int lat;
    signed_div_i = 1'b1; opdata1_i = 32'd50000; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++; $display("FAIL reset_mid got ready=%b result=%h exp ready=0 result=0", ready_o, result_o);
    end
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 32'd77, 32'd5, res, lat);
    n_tests++;
    if (lat != 34 || res !== {32'd2, 32'd15}) begin
      n_fail++; $display("FAIL reset_restart got lat=%0d result=%h exp lat=34 result=%h", lat, res, {32'd2, 32'd15});
    end
    drop_start();
  endtask

  task automatic test_back_to_back_random();
    logic [63:0] res, exp_res; int lat, exp_lat;
    bit sgn; logic [31:0] a, b;
    for (int k = 0; k < 40; k++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = 32'($urandom_range(1, 300));
        4:       b = -32'($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      if (k % 10 == 9) a = 32'h8000_0000;
      exp_res = model(sgn, a, b);
      exp_lat = (b == 32'd0) ? 2 : 34;
      run_op(sgn, a, b, res, lat);
      n_tests++;
      if (lat != exp_lat || res !== exp_res) begin
        n_fail++;
        $display("FAIL random_%0d s=%0b a=%h b=%h got lat=%0d res=%h exp lat=%0d res=%h",
                 k, sgn, a, b, lat, res, exp_lat, exp_res);
      end
      drop_start();
      n_tests++;
      if (ready_o !== 1'b0 || result_o !== 64'd0) begin
        n_fail++; $display("FAIL random_drop_%0d got ready=%b result=%h exp ready=0 result=0", k, ready_o, result_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed_vectors();
    test_div_zero();
    test_annul();
    test_reset_mid();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

endmodule
